// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the single-clock parameterised FIFO.
//   DefDsize   - default data word width in bits
//   DefAsize   - default address width (depth = 2**ASIZE)
//   fifo_depth - number of storage words for a given address width
package sync_fifo_pkg;

  localparam int unsigned DefDsize = 8;
  localparam int unsigned DefAsize = 4;

  function automatic int unsigned fifo_depth(input int unsigned asize);
    return 32'd1 << asize;
  endfunction

endpackage

// File: rtl/sfifo_mem.sv
// FIFO storage array: DSIZE x 2**ASIZE words, one synchronous write port and one
// asynchronous read port. Contents are never reset.
//   clk   - write clock
//   wen   - write enable; wdata is stored at waddr on the rising edge
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - combinational read data at raddr
module sfifo_mem #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned ASIZE = 4
) (
  input  logic             clk,
  input  logic             wen,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  logic [DSIZE-1:0] mem_q [2**ASIZE];

  always_ff @(posedge clk) begin
    if (wen) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, threshold flags and sticky error flags.
// Optional build macro: SYNC_FIFO_FWFT_EN selects first-word-fall-through reads
// (head word shown combinationally, zero read latency). Default build gives a
// registered rdata loaded on each accepted read with a one-cycle rvalid pulse.
//   clk, rst       - clock and synchronous active-high reset
//   winc, wdata    - write request and data (dropped when full)
//   rinc           - read request (rejected when empty)
//   rdata, rvalid  - read data and its qualifier
//   wfull, rempty  - occupancy == depth / occupancy == 0
//   walmost_full   - occupancy >= AFULL_TH
//   ralmost_empty  - occupancy <= AEMPTY_TH
//   wcount         - current occupancy, 0..depth
//   overflow       - sticky: write requested while full
//   underflow      - sticky: read requested while empty
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DSIZE     = DefDsize,
  parameter int unsigned ASIZE     = DefAsize,
  parameter int unsigned AFULL_TH  = fifo_depth(ASIZE) - 2,
  parameter int unsigned AEMPTY_TH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rvalid,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   wcount,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [ASIZE:0] DepthCnt = {1'b1, {ASIZE{1'b0}}};
  localparam logic [ASIZE:0] CntOne   = {{ASIZE{1'b0}}, 1'b1};
  localparam logic [ASIZE:0] AfullTh  = (ASIZE+1)'(AFULL_TH);
  localparam logic [ASIZE:0] AemptyTh = (ASIZE+1)'(AEMPTY_TH);

  logic [ASIZE:0]   wptr_q, wptr_d;
  logic [ASIZE:0]   rptr_q, rptr_d;
  logic [ASIZE:0]   count_q, count_d;
  logic             wfull_q, rempty_q, afull_q, aempty_q;
  logic             ovf_q, udf_q;
  logic             wr_en, rd_en;
  logic [DSIZE-1:0] mem_rdata;

  // Flags are registered from the previous edge's next-count, so they always
  // describe the current occupancy and can gate acceptance directly.
  assign wr_en = winc && !wfull_q;
  assign rd_en = rinc && !rempty_q;

  always_comb begin
    wptr_d  = wr_en ? wptr_q + CntOne : wptr_q;
    rptr_d  = rd_en ? rptr_q + CntOne : rptr_q;
    count_d = count_q;
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      wfull_q  <= (count_d == DepthCnt);
      rempty_q <= (count_d == '0);
      afull_q  <= (count_d >= AfullTh);
      aempty_q <= (count_d <= AemptyTh);
      if (winc && wfull_q) ovf_q <= 1'b1;
      if (rinc && rempty_q) udf_q <= 1'b1;
    end
  end

  sfifo_mem #(
    .DSIZE(DSIZE),
    .ASIZE(ASIZE)
  ) u_mem (
    .clk  (clk),
    .wen  (wr_en),
    .waddr(wptr_q[ASIZE-1:0]),
    .wdata(wdata),
    .raddr(rptr_q[ASIZE-1:0]),
    .rdata(mem_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Head word falls through; forced to zero so stale memory never shows.
  assign rdata  = rempty_q ? '0 : mem_rdata;
  assign rvalid = !rempty_q;
`else
  logic [DSIZE-1:0] rdata_q;
  logic             rvalid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_en;
      if (rd_en) rdata_q <= mem_rdata;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
`endif

  assign wfull         = wfull_q;
  assign rempty        = rempty_q;
  assign walmost_full  = afull_q;
  assign ralmost_empty = aempty_q;
  assign wcount        = count_q;
  assign overflow      = ovf_q;
  assign underflow     = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (DSIZE=8, ASIZE=4, AFULL_TH=14, AEMPTY_TH=2).
// The reference is a plain data queue plus sticky error bits; read data expected by
// the registered-read path is queued at the accepting edge and popped by a monitor
// on the falling edge whenever the DUT raises rvalid.
module tb_sync_fifo_param;

  localparam int Depth = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       winc;
  logic [7:0] wdata;
  logic       rinc;
  logic [7:0] rdata;
  logic       rvalid;
  logic       wfull;
  logic       rempty;
  logic       walmost_full;
  logic       ralmost_empty;
  logic [4:0] wcount;
  logic       overflow;
  logic       underflow;

  sync_fifo_param #(
    .DSIZE    (8),
    .ASIZE    (4),
    .AFULL_TH (14),
    .AEMPTY_TH(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .winc         (winc),
    .wdata        (wdata),
    .rinc         (rinc),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .wfull        (wfull),
    .rempty       (rempty),
    .walmost_full (walmost_full),
    .ralmost_empty(ralmost_empty),
    .wcount       (wcount),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_rd;
  bit         ovf_m, udf_m;
  bit         chk_en = 1'b0;
  int         n_vec  = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; the reference advances on the same rising edge.
  task automatic cycle(input bit w, input logic [7:0] d, input bit r, input bit rs);
    int sz;
    winc  = w;
    wdata = d;
    rinc  = r;
    rst   = rs;
    @(posedge clk);
    if (rs) begin
      model_q.delete();
      exp_q.delete();
      ovf_m   = 1'b0;
      udf_m   = 1'b0;
      last_rd = 8'h00;
    end else begin
      sz = model_q.size();
      if (w && sz == Depth) ovf_m = 1'b1;
      if (r && sz == 0) udf_m = 1'b1;
      if (r && sz != 0) begin
        last_rd = model_q.pop_front();
        exp_q.push_back(last_rd);
      end
      if (w && sz != Depth) model_q.push_back(d);
    end
    #1;
  endtask

  // Monitor: occupancy/flags every cycle, read data whenever the DUT presents it.
  always @(negedge clk) begin
    int         sz;
    logic [7:0] e;
    if (chk_en) begin
      sz = model_q.size();
      check("status {wcount,wfull,rempty,afull,aempty,ovf,udf}",
            {21'd0, wcount, wfull, rempty, walmost_full, ralmost_empty, overflow, underflow},
            {21'd0, 5'(sz), sz == Depth, sz == 0, sz >= 14, sz <= 2, ovf_m, udf_m});
`ifdef SYNC_FIFO_FWFT_EN
      exp_q.delete();
      check("rvalid", {31'd0, rvalid}, {31'd0, sz != 0});
      check("rdata head", {24'd0, rdata}, {24'd0, (sz != 0) ? model_q[0] : 8'h00});
`else
      check("rvalid", {31'd0, rvalid}, {31'd0, exp_q.size() != 0});
      if (rvalid && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("read data", {24'd0, rdata}, {24'd0, e});
      end
      check("rdata hold", {24'd0, rdata}, {24'd0, last_rd});
`endif
    end
  end

  initial begin
    int n;
    winc  = 1'b0;
    rinc  = 1'b0;
    wdata = 8'h00;
    rst   = 1'b1;
    // Reset wins over a concurrent write.
    cycle(1'b1, 8'h55, 1'b0, 1'b1);
    chk_en = 1'b1;
    cycle(1'b1, 8'h66, 1'b1, 1'b1);
    repeat (2) cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill 0x01..0x10, then a dropped 0xAA that sets overflow.
    for (int i = 1; i <= 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);

    // Drain in order, then one read while empty sets underflow.
    repeat (16) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill to 8, then 40 simultaneous read/write cycles to wrap the pointers.
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    repeat (8) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    repeat (40) cycle(1'b1, 8'($urandom), 1'b1, 1'b0);

    // Full with both requests, then empty with both requests.
    repeat (8) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b1, 1'b0);
    repeat (15) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 8'h5A, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset at occupancy 9 with a write pending.
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    repeat (9) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 8'h99, 1'b0, 1'b1);
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Random traffic with phases biased toward full and toward empty.
    for (int p = 0; p < 8; p++) begin
      n = 60;
      for (int i = 0; i < n; i++) begin
        cycle(($urandom_range(0, 9) < ((p % 2 == 0) ? 7 : 3)), 8'($urandom),
              ($urandom_range(0, 9) < ((p % 2 == 0) ? 3 : 7)),
              ($urandom_range(0, 199) == 0));
      end
    end

    repeat (2) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk_en = 1'b0;
    check("no outstanding reads", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
